branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Decode-stage companion to the global branch predictor. Holds each Fetch-stage prediction (tag, taken, target) in a small in-order FIFO until the branch resolves in Decode, and compares it with the actual outcome. Raises a registered mispredict/redirect to the front end and drives the predictor's update port. Clears wrong-path entries on mispredict or external flush.

## Interface
Parameters:
- DEPTH, 4 — in-flight prediction entries; power of two, ≥2
- TAG_WIDTH, 8 — PC tag width; matches predictor tag width

Ports:
- clk  in  1  — single clock
- reset  in  1  — synchronous, active-high
- stall  in  1  — pipeline stall; blocks push and resolve
- flush  in  1  — external flush; empties FIFO
- pushF  in  1  — Fetch has a predicted branch this cycle
- pcF  in  TAG_WIDTH  — Fetch branch tag
- prdF  in  1  — predicted taken
- prd_addrF  in  32  — predicted target
- resolveD  in  1  — Decode resolves a branch this cycle
- pcD  in  TAG_WIDTH  — resolving branch tag
- real_taken  in  1  — actual direction
- real_addr  in  32  — actual taken target
- fallthroughD  in  32  — PC of next sequential instruction
- mistakeD  out  1  — registered mispredict pulse
- redirect_pc  out  32  — registered correct next PC; valid with mistakeD
- upd_valid  out  1  — registered predictor-update strobe
- upd_tag  out  TAG_WIDTH  — update tag
- upd_taken  out  1  — update direction
- upd_addr  out  32  — update target
- full  out  1  — FIFO holds DEPTH entries
- empty  out  1  — FIFO holds 0 entries
- count  out  $clog2(DEPTH)+1  — occupancy

## Operation
- Circular FIFO; head/tail pointers wrap modulo DEPTH; count tracks occupancy.
- push = pushF & ~stall & ~full & ~mispredict_now. Push when full without a same-cycle pop: entry silently dropped.
- pop = resolveD & ~stall & ~empty.
- Effective prediction on resolve: head entry if ~empty and head tag == pcD; otherwise predicted not-taken, target 0. A mismatched head is still popped.
- mispredict_now = resolveD & ~stall & ((eff_prd != real_taken) | (eff_prd & real_taken & eff_addr != real_addr)).
- Correct PC: real_addr if real_taken, else fallthroughD.
- At any resolve (resolveD & ~stall), the next edge loads upd_valid=1, upd_tag=pcD, upd_taken=real_taken, upd_addr=real_addr. Otherwise upd_valid=0.
- On mispredict_now, the next edge sets mistakeD=1 and redirect_pc=correct PC. The FIFO is emptied at the same edge (count=0, pointers=0), because all younger entries are wrong-path.
- Same-cycle push on full with pop: push accepted; count stays DEPTH.
- Priority: reset > flush > mispredict_now clear > normal push/pop.
- flush empties the FIFO and forces mistakeD=0 and upd_valid=0 next cycle. A resolve in a flush cycle is ignored.

## Timing
- Reset values: mistakeD=0, redirect_pc=0, upd_valid=0, upd_tag=0, upd_taken=0, upd_addr=0, count=0, empty=1, full=0. FIFO contents are don't-care.
- Reset mid-operation discards all entries within one edge.
- mistakeD, redirect_pc, and upd_* have 1-cycle latency from resolve; each is a single-cycle pulse.
- full, empty, and count are registered-state derived; they are valid the cycle after the edge that changed them.
- With stall high: no state change except on reset or flush; the outputs mistakeD and upd_valid deassert.

## Configuration
- BRU_STATS_EN defined: adds outputs branch_cnt[31:0] and mispred_cnt[31:0].
  - branch_cnt increments on every accepted resolve.
  - mispred_cnt increments on every mispredict_now.
  - Both wrap at 2^32 and clear on reset only, not on flush.
- BRU_STATS_EN undefined: counters and ports are absent; all other behaviour is identical.

## Test plan
- Correct prediction: push pcF=0x12, prdF=1, prd_addrF=0x400; resolve pcD=0x12, real_taken=1, real_addr=0x400 -> next cycle mistakeD=0, upd_valid=1, upd_taken=1, count=0.
- Direction mispredict: push prdF=0 for pcF=0x34; resolve real_taken=1, real_addr=0x800 -> mistakeD=1, redirect_pc=0x800. Push two more entries before the resolve -> count=0 after it.
- Target mispredict with not-taken fallback: push prdF=1, prd_addrF=0x100; resolve real_taken=1, real_addr=0x200 -> redirect_pc=0x200. Separate case: prdF=1 with real_taken=0, fallthroughD=0x44 -> redirect_pc=0x44.
- Full/wrap: with DEPTH=4, push 4 -> full=1; a 5th push alone is dropped (count=4). Push plus resolve in one cycle -> count=4, pointers wrap, order preserved over 8 sequential resolves.
- Tag mismatch and empty: resolve pcD=0x55 with empty FIFO and real_taken=1 -> mistakeD=1. Resolve with real_taken=0 -> mistakeD=0, upd_valid=1.
- Flush/stall/reset: stall with resolveD -> no pop, upd_valid=0. flush with count=3 -> count=0. Assert reset mid-stream -> all outputs return to reset values next cycle. With BRU_STATS_EN, 5 resolves including 2 mispredicts -> branch_cnt=5, mispred_cnt=2.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Decode-stage branch resolve unit: in-order FIFO of Fetch predictions checked against Decode outcomes.
// Optional BRU_STATS_EN adds branch_cnt / mispred_cnt statistics outputs.
module branch_resolve_unit #(
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       pushF,
  input  logic [TAG_WIDTH-1:0]       pcF,
  input  logic                       prdF,
  input  logic [31:0]                prd_addrF,
  input  logic                       resolveD,
  input  logic [TAG_WIDTH-1:0]       pcD,
  input  logic                       real_taken,
  input  logic [31:0]                real_addr,
  input  logic [31:0]                fallthroughD,
  output logic                       mistakeD,
  output logic [31:0]                redirect_pc,
  output logic                       upd_valid,
  output logic [TAG_WIDTH-1:0]       upd_tag,
  output logic                       upd_taken,
  output logic [31:0]                upd_addr,
  output logic                       full,
  output logic                       empty,
`ifdef BRU_STATS_EN
  output logic [31:0]                branch_cnt,
  output logic [31:0]                mispred_cnt,
`endif
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TAG_WIDTH-1:0] tag_q  [DEPTH];
  logic                 prd_q  [DEPTH];
  logic [31:0]          addr_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic                 mistake_q;
  logic [31:0]          redirect_q;
  logic                 upd_valid_q;
  logic [TAG_WIDTH-1:0] upd_tag_q;
  logic                 upd_taken_q;
  logic [31:0]          upd_addr_q;

  logic        full_w, empty_w;
  logic        resolve_ok, head_match, eff_prd, mispredict_now, push, pop;
  logic [31:0] eff_addr, correct_pc;

  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);

  // A resolve coinciding with a flush is discarded entirely.
  assign resolve_ok = resolveD & ~stall & ~flush;
  assign head_match = ~empty_w & (tag_q[head_q] == pcD);
  assign eff_prd    = head_match ? prd_q[head_q]  : 1'b0;
  assign eff_addr   = head_match ? addr_q[head_q] : 32'd0;

  assign mispredict_now = resolve_ok &
                          ((eff_prd != real_taken) |
                           (eff_prd & real_taken & (eff_addr != real_addr)));
  assign correct_pc = real_taken ? real_addr : fallthroughD;

  assign pop  = resolve_ok & ~empty_w;
  assign push = pushF & ~stall & ~flush & ~reset & ~mispredict_now & (~full_w | pop);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush || mispredict_now) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_q[tail_q]  <= pcF;
      prd_q[tail_q]  <= prdF;
      addr_q[tail_q] <= prd_addrF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      mistake_q   <= 1'b0;
      redirect_q  <= '0;
      upd_valid_q <= 1'b0;
      upd_tag_q   <= '0;
      upd_taken_q <= 1'b0;
      upd_addr_q  <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      mistake_q   <= mispredict_now;
      upd_valid_q <= resolve_ok;
      if (mispredict_now) redirect_q <= correct_pc;
      if (resolve_ok) begin
        upd_tag_q   <= pcD;
        upd_taken_q <= real_taken;
        upd_addr_q  <= real_addr;
      end
    end
  end

`ifdef BRU_STATS_EN
  logic [31:0] branch_cnt_q, mispred_cnt_q;

  // Statistics survive flushes; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (resolve_ok)     branch_cnt_q  <= branch_cnt_q + 32'd1;
      if (mispredict_now) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
`endif

  assign mistakeD    = mistake_q;
  assign redirect_pc = redirect_q;
  assign upd_valid   = upd_valid_q;
  assign upd_tag     = upd_tag_q;
  assign upd_taken   = upd_taken_q;
  assign upd_addr    = upd_addr_q;
  assign full        = full_w;
  assign empty       = empty_w;
  assign count       = count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (DEPTH=4, TAG_WIDTH=8).
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset, stall, flush, pushF, prdF, resolveD, real_taken;
  logic [7:0]  pcF, pcD;
  logic [31:0] prd_addrF, real_addr, fallthroughD;
  logic        mistakeD, upd_valid, upd_taken, full, empty;
  logic [31:0] redirect_pc, upd_addr;
  logic [7:0]  upd_tag;
  logic [2:0]  count;
`ifdef BRU_STATS_EN
  logic [31:0] branch_cnt, mispred_cnt;
`endif

  int passed = 0;
  int total  = 0;

  branch_resolve_unit #(.DEPTH(4), .TAG_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .pushF(pushF), .pcF(pcF), .prdF(prdF), .prd_addrF(prd_addrF),
    .resolveD(resolveD), .pcD(pcD), .real_taken(real_taken),
    .real_addr(real_addr), .fallthroughD(fallthroughD),
    .mistakeD(mistakeD), .redirect_pc(redirect_pc), .upd_valid(upd_valid),
    .upd_tag(upd_tag), .upd_taken(upd_taken), .upd_addr(upd_addr),
    .full(full), .empty(empty),
`ifdef BRU_STATS_EN
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic idle();
    reset = 0; stall = 0; flush = 0; pushF = 0; resolveD = 0;
    pcF = '0; prdF = 0; prd_addrF = '0;
    pcD = '0; real_taken = 0; real_addr = '0; fallthroughD = '0;
  endtask

  // Advance one edge and settle so registered outputs reflect that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic [7:0] t, input logic p, input logic [31:0] a);
    pushF = 1; pcF = t; prdF = p; prd_addrF = a;
  endtask

  task automatic set_resolve(input logic [7:0] t, input logic tk, input logic [31:0] a,
                             input logic [31:0] ft);
    resolveD = 1; pcD = t; real_taken = tk; real_addr = a; fallthroughD = ft;
  endtask

  task automatic do_push(input logic [7:0] t, input logic p, input logic [31:0] a);
    set_push(t, p, a); step(); idle();
  endtask

  task automatic do_resolve(input logic [7:0] t, input logic tk, input logic [31:0] a,
                            input logic [31:0] ft);
    set_resolve(t, tk, a, ft); step(); idle();
  endtask

  task automatic test_reset();
    idle(); reset = 1; step(); step(); idle();
    total++; if (mistakeD !== 1'b0) $display("FAIL rst_mistake got %0h exp 0", mistakeD); else passed++;
    total++; if (redirect_pc !== 32'h0) $display("FAIL rst_redirect got %0h exp 0", redirect_pc); else passed++;
    total++; if (upd_valid !== 1'b0) $display("FAIL rst_upd_valid got %0h exp 0", upd_valid); else passed++;
    total++; if (upd_tag !== 8'h0) $display("FAIL rst_upd_tag got %0h exp 0", upd_tag); else passed++;
    total++; if (upd_taken !== 1'b0) $display("FAIL rst_upd_taken got %0h exp 0", upd_taken); else passed++;
    total++; if (upd_addr !== 32'h0) $display("FAIL rst_upd_addr got %0h exp 0", upd_addr); else passed++;
    total++; if (count !== 3'd0) $display("FAIL rst_count got %0d exp 0", count); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL rst_empty got %0h exp 1", empty); else passed++;
    total++; if (full !== 1'b0) $display("FAIL rst_full got %0h exp 0", full); else passed++;
  endtask

  task automatic test_correct();
    do_push(8'h12, 1, 32'h400);
    total++; if (count !== 3'd1) $display("FAIL corr_count_push got %0d exp 1", count); else passed++;
    total++; if (empty !== 1'b0) $display("FAIL corr_empty_push got %0h exp 0", empty); else passed++;
    do_resolve(8'h12, 1, 32'h400, 32'h104);
    total++; if (mistakeD !== 1'b0) $display("FAIL corr_mistake got %0h exp 0", mistakeD); else passed++;
    total++; if (upd_valid !== 1'b1) $display("FAIL corr_upd_valid got %0h exp 1", upd_valid); else passed++;
    total++; if (upd_taken !== 1'b1) $display("FAIL corr_upd_taken got %0h exp 1", upd_taken); else passed++;
    total++; if (upd_tag !== 8'h12) $display("FAIL corr_upd_tag got %0h exp 12", upd_tag); else passed++;
    total++; if (upd_addr !== 32'h400) $display("FAIL corr_upd_addr got %0h exp 400", upd_addr); else passed++;
    total++; if (count !== 3'd0) $display("FAIL corr_count got %0d exp 0", count); else passed++;
    step();
    total++; if (upd_valid !== 1'b0) $display("FAIL corr_upd_pulse got %0h exp 0", upd_valid); else passed++;
  endtask

  task automatic test_dir_mispredict();
    do_push(8'h34, 0, 32'h0);
    do_push(8'h35, 1, 32'h10);
    do_push(8'h36, 0, 32'h0);
    total++; if (count !== 3'd3) $display("FAIL dir_count_pre got %0d exp 3", count); else passed++;
    do_resolve(8'h34, 1, 32'h800, 32'h38);
    total++; if (mistakeD !== 1'b1) $display("FAIL dir_mistake got %0h exp 1", mistakeD); else passed++;
    total++; if (redirect_pc !== 32'h800) $display("FAIL dir_redirect got %0h exp 800", redirect_pc); else passed++;
    total++; if (count !== 3'd0) $display("FAIL dir_count_post got %0d exp 0", count); else passed++;
    step();
    total++; if (mistakeD !== 1'b0) $display("FAIL dir_mistake_pulse got %0h exp 0", mistakeD); else passed++;
  endtask

  task automatic test_target_mispredict();
    do_push(8'h40, 1, 32'h100);
    do_resolve(8'h40, 1, 32'h200, 32'h44);
    total++; if (mistakeD !== 1'b1) $display("FAIL tgt_mistake got %0h exp 1", mistakeD); else passed++;
    total++; if (redirect_pc !== 32'h200) $display("FAIL tgt_redirect got %0h exp 200", redirect_pc); else passed++;
    do_push(8'h41, 1, 32'h100);
    do_resolve(8'h41, 0, 32'h0, 32'h44);
    total++; if (mistakeD !== 1'b1) $display("FAIL nt_mistake got %0h exp 1", mistakeD); else passed++;
    total++; if (redirect_pc !== 32'h44) $display("FAIL nt_redirect got %0h exp 44", redirect_pc); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL nt_empty got %0h exp 1", empty); else passed++;
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 4; i++) do_push(8'h60 + 8'(i), 1, 32'h1060 + 32'(i));
    total++; if (full !== 1'b1) $display("FAIL wrap_full got %0h exp 1", full); else passed++;
    total++; if (count !== 3'd4) $display("FAIL wrap_count4 got %0d exp 4", count); else passed++;
    do_push(8'hEE, 0, 32'h0);
    total++; if (count !== 3'd4) $display("FAIL wrap_drop_count got %0d exp 4", count); else passed++;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) set_push(8'h64 + 8'(k), 1, 32'h1064 + 32'(k));
      set_resolve(8'h60 + 8'(k), 1, 32'h1060 + 32'(k), 32'h0);
      step(); idle();
      total++; if (mistakeD !== 1'b0) $display("FAIL wrap_order_%0d mistake got %0h exp 0", k, mistakeD); else passed++;
      total++; if (count !== ((k < 4) ? 3'd4 : 3'(7 - k)))
        $display("FAIL wrap_count_%0d got %0d exp %0d", k, count, (k < 4) ? 4 : 7 - k); else passed++;
    end
    total++; if (empty !== 1'b1) $display("FAIL wrap_empty_end got %0h exp 1", empty); else passed++;
  endtask

  task automatic test_tag_mismatch();
    do_resolve(8'h55, 1, 32'h300, 32'h58);
    total++; if (mistakeD !== 1'b1) $display("FAIL empty_tk_mistake got %0h exp 1", mistakeD); else passed++;
    total++; if (redirect_pc !== 32'h300) $display("FAIL empty_tk_redirect got %0h exp 300", redirect_pc); else passed++;
    do_resolve(8'h55, 0, 32'h0, 32'h58);
    total++; if (mistakeD !== 1'b0) $display("FAIL empty_nt_mistake got %0h exp 0", mistakeD); else passed++;
    total++; if (upd_valid !== 1'b1) $display("FAIL empty_nt_upd_valid got %0h exp 1", upd_valid); else passed++;
    total++; if (upd_taken !== 1'b0) $display("FAIL empty_nt_upd_taken got %0h exp 0", upd_taken); else passed++;
    do_push(8'h70, 1, 32'h700);
    do_resolve(8'h71, 0, 32'h0, 32'h74);
    total++; if (mistakeD !== 1'b0) $display("FAIL mism_mistake got %0h exp 0", mistakeD); else passed++;
    total++; if (count !== 3'd0) $display("FAIL mism_popped got %0d exp 0", count); else passed++;
  endtask

  task automatic test_stall_flush();
    do_push(8'h80, 0, 32'h0);
    do_push(8'h81, 0, 32'h0);
    do_push(8'h82, 0, 32'h0);
    stall = 1; set_resolve(8'h80, 1, 32'h900, 32'h84); set_push(8'h83, 0, 32'h0);
    step(); idle();
    total++; if (upd_valid !== 1'b0) $display("FAIL stall_upd_valid got %0h exp 0", upd_valid); else passed++;
    total++; if (mistakeD !== 1'b0) $display("FAIL stall_mistake got %0h exp 0", mistakeD); else passed++;
    total++; if (count !== 3'd3) $display("FAIL stall_count got %0d exp 3", count); else passed++;
    flush = 1; set_resolve(8'h80, 1, 32'h900, 32'h84);
    step(); idle();
    total++; if (count !== 3'd0) $display("FAIL flush_count got %0d exp 0", count); else passed++;
    total++; if (mistakeD !== 1'b0) $display("FAIL flush_mistake got %0h exp 0", mistakeD); else passed++;
    total++; if (upd_valid !== 1'b0) $display("FAIL flush_upd_valid got %0h exp 0", upd_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    do_push(8'h90, 1, 32'hA00);
    do_push(8'h91, 0, 32'h0);
    set_resolve(8'h90, 1, 32'hA00, 32'h94); step();
    total++; if (mistakeD !== 1'b0) $display("FAIL b2b_first_mistake got %0h exp 0", mistakeD); else passed++;
    set_resolve(8'h91, 1, 32'hB00, 32'h98); step(); idle();
    total++; if (mistakeD !== 1'b1) $display("FAIL b2b_second_mistake got %0h exp 1", mistakeD); else passed++;
    total++; if (redirect_pc !== 32'hB00) $display("FAIL b2b_redirect got %0h exp b00", redirect_pc); else passed++;
    total++; if (upd_tag !== 8'h91) $display("FAIL b2b_upd_tag got %0h exp 91", upd_tag); else passed++;
  endtask

  task automatic test_reset_mid();
    do_push(8'hA0, 0, 32'h0);
    do_push(8'hA1, 0, 32'h0);
    do_resolve(8'hA0, 1, 32'hC00, 32'hA4);
    do_push(8'hA2, 0, 32'h0);
    reset = 1; set_resolve(8'hA2, 1, 32'hD00, 32'hA8);
    step(); idle();
    total++; if (mistakeD !== 1'b0) $display("FAIL rmid_mistake got %0h exp 0", mistakeD); else passed++;
    total++; if (redirect_pc !== 32'h0) $display("FAIL rmid_redirect got %0h exp 0", redirect_pc); else passed++;
    total++; if (upd_valid !== 1'b0) $display("FAIL rmid_upd_valid got %0h exp 0", upd_valid); else passed++;
    total++; if (upd_tag !== 8'h0) $display("FAIL rmid_upd_tag got %0h exp 0", upd_tag); else passed++;
    total++; if (upd_addr !== 32'h0) $display("FAIL rmid_upd_addr got %0h exp 0", upd_addr); else passed++;
    total++; if (count !== 3'd0) $display("FAIL rmid_count got %0d exp 0", count); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL rmid_empty got %0h exp 1", empty); else passed++;
  endtask

`ifdef BRU_STATS_EN
  task automatic test_stats();
    idle(); reset = 1; step(); idle();
    for (int i = 0; i < 3; i++) do_resolve(8'h01, 0, 32'h0, 32'h8);
    for (int i = 0; i < 2; i++) do_resolve(8'h02, 1, 32'h500, 32'hC);
    total++; if (branch_cnt !== 32'd5) $display("FAIL stats_branch got %0d exp 5", branch_cnt); else passed++;
    total++; if (mispred_cnt !== 32'd2) $display("FAIL stats_mispred got %0d exp 2", mispred_cnt); else passed++;
    flush = 1; step(); idle();
    total++; if (branch_cnt !== 32'd5) $display("FAIL stats_flush_keep got %0d exp 5", branch_cnt); else passed++;
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_correct();
    test_dir_mispredict();
    test_target_mispredict();
    test_full_wrap();
    test_tag_mismatch();
    test_stall_flush();
    test_back_to_back();
    test_reset_mid();
`ifdef BRU_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
